// File: rtl/seven_segment_to_binary.sv
// seven_segment_to_binary
//   Watches a set of 7-segment drive pins (A..G, active-high) and turns them back
//   into a 4-bit value. The pins are synchronised with two flops. Each new pattern
//   must then hold for STABLE_CYCLES samples before it is accepted. Each accepted
//   change produces one report, classified as a digit, a blank or an error.
//
// Ports
//   i_Clk                    system clock, rising edge
//   i_Rst_L                  synchronous reset, active-low
//   i_mode[1:0]              00/10/11 hex decode, 01 decimal only (A-F -> error)
//   i_Segment_A..G           segment pins, pattern bit 6 (A) down to bit 0 (G)
//   o_Binary_Num[3:0]        decoded value of last accepted pattern (0 if blank/error)
//   o_Pattern[6:0]           raw last accepted pattern {A..G}
//   o_Blank                  last accepted pattern was all-off
//   o_Error                  last accepted pattern not decodable in the sampled mode
//   o_Valid                  one-cycle pulse when the outputs above update
module seven_segment_to_binary #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [1:0] i_mode,
  input  logic       i_Segment_A,
  input  logic       i_Segment_B,
  input  logic       i_Segment_C,
  input  logic       i_Segment_D,
  input  logic       i_Segment_E,
  input  logic       i_Segment_F,
  input  logic       i_Segment_G,
  output logic [3:0] o_Binary_Num,
  output logic [6:0] o_Pattern,
  output logic       o_Blank,
  output logic       o_Error,
  output logic       o_Valid
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, REPORT} state_t;

  logic [6:0] pins;
  logic [6:0] sync1_reg, sync2_reg;

  state_t     state_reg, state_next;
  logic [6:0] cand_reg, cand_next;
  logic [6:0] accepted_reg, accepted_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic       first_reg, first_next;

  logic [3:0] dec_num;
  logic       dec_blank, dec_error, dec_letter, dec_known;
  logic       report;

  logic [3:0] num_reg;
  logic [6:0] pattern_reg;
  logic       blank_reg, error_reg, valid_reg;

  assign pins = {i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                 i_Segment_E, i_Segment_F, i_Segment_G};

  // Two-flop synchroniser. The pins come from another driver and are asynchronous to i_Clk.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= pins;
      sync2_reg <= sync1_reg;
    end
  end

  // State register and the settle datapath that travels with it.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_reg    <= IDLE;
      cand_reg     <= '0;
      accepted_reg <= '0;
      cnt_reg      <= '0;
      first_reg    <= 1'b1;
    end else begin
      state_reg    <= state_next;
      cand_reg     <= cand_next;
      accepted_reg <= accepted_next;
      cnt_reg      <= cnt_next;
      first_reg    <= first_next;
    end
  end

  // Saturating increment, so a long-stable candidate can never wrap back to a low count.
  assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

  // Next-state logic.
  always_comb begin
    state_next    = state_reg;
    cand_next     = cand_reg;
    accepted_next = accepted_reg;
    cnt_next      = cnt_reg;
    first_next    = first_reg;
    case (state_reg)
      IDLE: begin
        // After reset the first pattern is reported even if it equals the reset value.
        if ((sync2_reg != accepted_reg) || first_reg) begin
          cand_next = sync2_reg;
          cnt_next  = CNT_W'(1);
          // With a one-sample window the loading sample already completes the settle.
          state_next = (STABLE_CYCLES <= 1) ? REPORT : SETTLE;
        end
      end
      SETTLE: begin
        if (sync2_reg == cand_reg) begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_MAX)
            state_next = REPORT;
        end else if ((sync2_reg == accepted_reg) && !first_reg) begin
          // A glitch that returns to the accepted pattern is dropped without a report.
          state_next = IDLE;
        end else begin
          cand_next = sync2_reg;
          cnt_next  = CNT_W'(1);
        end
      end
      REPORT: begin
        accepted_next = cand_reg;
        first_next    = 1'b0;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: decode the candidate using the mode present in the report cycle.
  always_comb begin
    dec_num    = 4'h0;
    dec_known  = 1'b1;
    dec_letter = 1'b0;
    case (cand_reg)
      7'h7E: dec_num = 4'h0;
      7'h30: dec_num = 4'h1;
      7'h6D: dec_num = 4'h2;
      7'h79: dec_num = 4'h3;
      7'h33: dec_num = 4'h4;
      7'h5B: dec_num = 4'h5;
      7'h5F: dec_num = 4'h6;
      7'h70: dec_num = 4'h7;
      7'h7F: dec_num = 4'h8;
      7'h7B: dec_num = 4'h9;
      7'h77: begin dec_num = 4'hA; dec_letter = 1'b1; end
      7'h1F: begin dec_num = 4'hB; dec_letter = 1'b1; end
      7'h4E: begin dec_num = 4'hC; dec_letter = 1'b1; end
      7'h3D: begin dec_num = 4'hD; dec_letter = 1'b1; end
      7'h4F: begin dec_num = 4'hE; dec_letter = 1'b1; end
      7'h47: begin dec_num = 4'hF; dec_letter = 1'b1; end
      default: dec_known = 1'b0;
    endcase
    dec_blank = (cand_reg == 7'h00);
    dec_error = !dec_blank && (!dec_known || (dec_letter && (i_mode == 2'b01)));
    if (dec_blank || dec_error)
      dec_num = 4'h0;
    report = (state_reg == REPORT);
  end

  // Report registers. They hold their value between reports.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      num_reg     <= '0;
      pattern_reg <= '0;
      blank_reg   <= 1'b0;
      error_reg   <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      valid_reg <= report;
      if (report) begin
        num_reg     <= dec_num;
        pattern_reg <= cand_reg;
        blank_reg   <= dec_blank;
        error_reg   <= dec_error;
      end
    end
  end

  assign o_Binary_Num = num_reg;
  assign o_Pattern    = pattern_reg;
  assign o_Blank      = blank_reg;
  assign o_Error      = error_reg;
  assign o_Valid      = valid_reg;

endmodule

// File: tb/tb_seven_segment_to_binary.sv
// tb_seven_segment_to_binary
//   Directed bench for seven_segment_to_binary with STABLE_CYCLES = 16.
//   Inputs change on the falling edge, and outputs are sampled on the falling edge.
module tb_seven_segment_to_binary;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic [1:0] i_mode = 2'b00;
  logic [6:0] pins = 7'h00;
  logic [3:0] o_Binary_Num;
  logic [6:0] o_Pattern;
  logic       o_Blank, o_Error, o_Valid;

  int tests_run = 0;
  int tests_failed = 0;
  int lat;
  int pulses;

  always #5 i_Clk = ~i_Clk;

  seven_segment_to_binary #(.STABLE_CYCLES(16)) dut (
    .i_Clk        (i_Clk),
    .i_Rst_L      (i_Rst_L),
    .i_mode       (i_mode),
    .i_Segment_A  (pins[6]),
    .i_Segment_B  (pins[5]),
    .i_Segment_C  (pins[4]),
    .i_Segment_D  (pins[3]),
    .i_Segment_E  (pins[2]),
    .i_Segment_F  (pins[1]),
    .i_Segment_G  (pins[0]),
    .o_Binary_Num (o_Binary_Num),
    .o_Pattern    (o_Pattern),
    .o_Blank      (o_Blank),
    .o_Error      (o_Error),
    .o_Valid      (o_Valid)
  );

  task automatic check_eq(input string tag, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end else begin
      $display("[TB] %s ok (%0h)", tag, actual);
    end
  endtask

  // Returns the number of falling edges until o_Valid is seen, or 0 on timeout.
  task automatic wait_valid(input int max_clks, output int clks);
    clks = 0;
    for (int i = 1; i <= max_clks; i++) begin
      @(negedge i_Clk);
      if (o_Valid) begin
        clks = i;
        break;
      end
    end
  endtask

  task automatic count_valid(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge i_Clk);
      if (o_Valid) cnt++;
    end
  endtask

  task automatic check_report(input string tag, input int num, input int pat,
                              input int blank, input int err);
    check_eq({tag, "_num"},   int'(o_Binary_Num), num);
    check_eq({tag, "_pat"},   int'(o_Pattern),    pat);
    check_eq({tag, "_blank"}, int'(o_Blank),      blank);
    check_eq({tag, "_err"},   int'(o_Error),      err);
  endtask

  initial begin
    // T1: reset held with 5B on the pins, then the first report comes after release.
    pins    = 7'h5B;
    i_Rst_L = 1'b0;
    repeat (3) @(negedge i_Clk);
    check_eq("t1_rst_valid", int'(o_Valid), 0);
    check_report("t1_rst", 0, 0, 0, 0);
    i_Rst_L = 1'b1;
    wait_valid(40, lat);
    check_eq("t1_latency", lat, 19);
    check_report("t1", 5, 'h5B, 0, 0);
    @(negedge i_Clk);
    check_eq("t1_pulse_width", int'(o_Valid), 0);

    // T2: change to F.
    pins = 7'h47;
    wait_valid(40, lat);
    check_eq("t2_latency", lat, 19);
    check_report("t2", 'hF, 'h47, 0, 0);

    // T3: a 10-clock glitch to 7F is filtered out.
    pins = 7'h30;
    wait_valid(40, lat);
    check_eq("t3_latency", lat, 19);
    check_report("t3_pre", 1, 'h30, 0, 0);
    pins = 7'h7F;
    repeat (10) @(negedge i_Clk);
    pins = 7'h30;
    count_valid(40, pulses);
    check_eq("t3_glitch_pulses", pulses, 0);
    check_report("t3_post", 1, 'h30, 0, 0);

    // T4: decimal mode rejects letters. Then check blank, an illegal code, and hex mode.
    i_mode = 2'b01;
    pins   = 7'h77;
    wait_valid(40, lat);
    check_eq("t4a_latency", lat, 19);
    check_report("t4a", 0, 'h77, 0, 1);
    pins = 7'h00;
    wait_valid(40, lat);
    check_eq("t4b_latency", lat, 19);
    check_report("t4b", 0, 0, 1, 0);
    pins = 7'h12;
    wait_valid(40, lat);
    check_eq("t4c_latency", lat, 19);
    check_report("t4c", 0, 'h12, 0, 1);
    i_mode = 2'b10;
    pins   = 7'h4E;
    wait_valid(40, lat);
    check_eq("t4d_latency", lat, 19);
    check_report("t4d", 'hC, 'h4E, 0, 0);
    i_mode = 2'b01;
    count_valid(30, pulses);
    check_eq("t4e_mode_only_pulses", pulses, 0);
    check_report("t4e", 'hC, 'h4E, 0, 0);

    // T5: reset lands in the middle of SETTLE. The pending pattern is dropped and re-qualified.
    i_mode = 2'b00;
    pins   = 7'h6D;
    repeat (10) @(negedge i_Clk);
    i_Rst_L = 1'b0;
    @(negedge i_Clk);
    check_eq("t5_rst_valid", int'(o_Valid), 0);
    check_report("t5_rst", 0, 0, 0, 0);
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    wait_valid(40, lat);
    check_eq("t5_latency", lat, 19);
    check_report("t5", 2, 'h6D, 0, 0);

    // T6: static pins produce no further reports.
    count_valid(200, pulses);
    check_eq("t6_static_pulses", pulses, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
